down_counter_timer: RTL and testbench

//  Loadable WIDTH-bit down counter with start/pause/stop control and terminal-count signalling.

---
 rtl/down_counter_timer.sv | 129 ++++++++++++
 tb/tb_down_counter_timer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_timer
// Description : Loadable WIDTH-bit down counter / interval timer with
//               start, pause and stop control and a terminal-count pulse.
//               Define DOWN_COUNTER_AUTO_RELOAD_EN for periodic (reload) mode.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_next;
  logic             tc_next;

  // State register together with the datapath registers it steers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      reload_q <= '0;
      tc       <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      reload_q <= reload_next;
      tc       <= tc_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload_q;
    tc_next     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          count_next  = load_val;
          reload_next = load_val;
        end else if (start) begin
          if (count == ZERO) begin
            state_next = ST_DONE;
            tc_next    = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (pause) begin
          state_next = ST_PAUSE;
        end else if (count == ZERO) begin
          // Only reachable in periodic mode: the one cycle spent at zero.
          if (AUTO_RELOAD && (reload_q != ZERO)) begin
            count_next = reload_q;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          count_next = count - ONE;
          if (count == ONE) begin
            tc_next = 1'b1;
            if (!AUTO_RELOAD || (reload_q == ZERO)) begin
              state_next = ST_DONE;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (!pause) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        count_next = ZERO;
        if (load) begin
          count_next  = load_val;
          reload_next = load_val;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_PAUSE);
    done = (state == ST_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_counter_timer
// Description : Randomized scoreboard bench for down_counter_timer against a
//               behavioural timer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_timer;
  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic             clk      = 1'b0;
  logic             reset_n  = 1'b0;
  logic             load     = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             start    = 1'b0;
  logic             pause    = 1'b0;
  logic             stop     = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .stop(stop),
    .count(count), .busy(busy), .tc(tc), .done(done)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             tc;
    logic             done;
  } exp_t;

  exp_t exp_q[$];

  // Timer model: a value, whether it is running / paused / finished.
  int m_count  = 0;
  int m_reload = 0;
  bit m_run    = 1'b0;
  bit m_pause  = 1'b0;
  bit m_done   = 1'b0;

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_run = 0; m_pause = 0; m_done = 0;
  endtask

  task automatic step(input bit ld, input int v, input bit st, input bit ps, input bit sp);
    exp_t e;
    bit   t;
    @(negedge clk);
    load = ld; load_val = WIDTH'(v); start = st; pause = ps; stop = sp;
    t = 1'b0;
    if (!m_run && !m_pause) begin
      if (ld) begin
        m_count = v; m_reload = v; m_done = 0;
      end else if (!m_done && st) begin
        if (m_count == 0) begin m_done = 1; t = 1; end
        else m_run = 1;
      end
    end else if (sp) begin
      m_run = 0; m_pause = 0;
    end else if (ps) begin
      m_run = 0; m_pause = 1;
    end else if (m_pause) begin
      m_pause = 0; m_run = 1;
    end else if (m_count > 0) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        t = 1;
        if (!AUTO || m_reload == 0) begin m_run = 0; m_done = 1; end
      end
    end else if (AUTO && m_reload != 0) begin
      m_count = m_reload;
    end else begin
      m_run = 0; m_done = 1;
    end
    e.cnt  = WIDTH'(m_count);
    e.busy = m_run || m_pause;
    e.tc   = t;
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  // Reset lands between clock edges; outputs must clear without waiting for one.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (count !== '0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%0d busy=%b tc=%b done=%b required all zero",
               count, busy, tc, done);
    end
    model_reset();
    exp_q.delete();
    load = 0; start = 0; pause = 0; stop = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({count, busy, tc, done} !== e) begin
        failures++;
        $display("FAIL cycle t=%0t got count=%0d busy=%b tc=%b done=%b exp count=%0d busy=%b tc=%b done=%b",
                 $time, count, busy, tc, done, e.cnt, e.busy, e.tc, e.done);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();

    // one-shot from 3
    step(1, 3, 0, 0, 0); step(0, 0, 1, 0, 0); idle(5);

    // pause at 6 for three cycles, stop at 4
    step(1, 10, 0, 0, 0); step(0, 0, 1, 0, 0); idle(4);
    repeat (3) step(0, 0, 0, 1, 0);
    idle(3); step(0, 0, 0, 0, 1); idle(2);

    // start from zero, load+start together, load during RUN
    step(1, 0, 0, 0, 0); step(0, 0, 1, 0, 0); idle(2);
    step(1, 7, 1, 0, 0); idle(1); step(0, 0, 1, 0, 0);
    step(1, 2, 1, 0, 0); idle(2); step(0, 0, 0, 0, 1); idle(1);

    // reset mid-run with count 5
    step(1, 5, 0, 0, 0); step(0, 0, 1, 0, 0);
    do_reset();

    if (AUTO) begin
      step(1, 2, 0, 0, 0); step(0, 0, 1, 0, 0); idle(8);
      step(0, 0, 0, 0, 1); idle(1);
      step(1, 0, 0, 0, 0); step(0, 0, 1, 0, 0); idle(3);
      step(1, 1, 0, 0, 0); step(0, 0, 1, 0, 0); idle(5);
      step(0, 0, 0, 0, 1); idle(1);
    end

    // full-scale latency: tc on the 2**WIDTH-th edge counting the start edge
    step(1, MAXV, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    n = 0;
    while (n < MAXV + 50) begin
      @(posedge clk);
      #2;
      n++;
      if (tc === 1'b1) break;
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (n != MAXV + 1) begin
      failures++;
      $display("FAIL max_latency edges=%0d required=%0d", n, MAXV + 1);
    end
    step(0, 0, 0, 0, 1); idle(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        int v;
        v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXV)) : int'($urandom_range(0, 6));
        step($urandom_range(0, 7) == 0, v, $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
      end
    end

    idle(1);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
